// File: rtl/apb_gpio_ext.sv
// apb_gpio_ext: APB GPIO with input synchronisers, per-pin debounce, set/clear outputs and per-pin interrupts
module apb_gpio_ext #(
    parameter int                 PortWidth = 16,
    parameter int                 DbWidth   = 8,
    parameter logic [DbWidth-1:0] DbDefault = 8'd4
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 PSEL,
    input  logic [7:2]           PADDR,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [31:0]          PWDATA,
    output logic [31:0]          PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    input  logic [PortWidth-1:0] PORTIN,
    output logic [PortWidth-1:0] PORTOUT,
    output logic [PortWidth-1:0] PORTEN,
    output logic [PortWidth-1:0] GPIOINT,
    output logic                 COMBINT
);
    logic [PortWidth-1:0] sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
    logic [PortWidth-1:0] dout_q, dout_d, oen_q, oen_d, inten_q, inten_d;
    logic [PortWidth-1:0] inttype_q, inttype_d, intpol_q, intpol_d, intboth_q, intboth_d;
    logic [PortWidth-1:0] intstat_q, intstat_d, dben_q, dben_d;
    logic [DbWidth-1:0]   dbcnt_q, dbcnt_d, thr;
    logic [DbWidth-1:0]   cnt_q [PortWidth];
    logic [DbWidth-1:0]   cnt_d [PortWidth];
    logic [DbWidth:0]     inc;
    logic [PortWidth-1:0] wdata, rise, fall, set;
    logic [31:0]          rdata;
    logic                 access, mapped, wr;
    logic                 unused_pwdata;

    assign access        = PSEL & PENABLE;
    assign mapped        = PADDR < 6'd12;
    assign wr            = access & PWRITE & mapped;
    assign wdata         = PWDATA[PortWidth-1:0];
    assign unused_pwdata = ^PWDATA;
    assign thr           = (dbcnt_q == '0) ? DbWidth'(1) : dbcnt_q;
    assign PREADY        = 1'b1;
    assign PSLVERR       = access & ~mapped;
    assign PRDATA        = access ? rdata : '0;
    assign PORTOUT       = dout_q;
    assign PORTEN        = oen_q;
    assign GPIOINT       = intstat_q & inten_q;
    assign COMBINT       = |GPIOINT;

    // two-stage synchroniser, then a per-pin stability counter gates changes into filt
    always_comb begin
        sync1_d = PORTIN;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        inc     = '0;
        for (int i = 0; i < PortWidth; i++) begin
            inc = {1'b0, cnt_q[i]} + (DbWidth+1)'(1);
            if (!dben_q[i]) begin
                filt_d[i] = sync2_q[i];
            end else if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (inc >= {1'b0, thr}) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = inc[DbWidth] ? cnt_q[i] : inc[DbWidth-1:0];
            end
        end
    end

    // edges compare the filter value being loaded against the one it replaces; set beats W1C
    always_comb begin
        rise      = filt_d & ~filt_q;
        fall      = ~filt_d & filt_q;
        set       = (inttype_q & ((intboth_q & (rise | fall)) | (~intboth_q & ((intpol_q & rise) | (~intpol_q & fall)))))
                  | (~inttype_q & ~(filt_d ^ intpol_q));
        dout_d    = dout_q;
        oen_d     = oen_q;
        inten_d   = inten_q;
        inttype_d = inttype_q;
        intpol_d  = intpol_q;
        intboth_d = intboth_q;
        intstat_d = intstat_q | set;
        dben_d    = dben_q;
        dbcnt_d   = dbcnt_q;
        if (wr) begin
            case (PADDR)
                6'd1:    dout_d    = wdata;
                6'd2:    dout_d    = dout_q | wdata;
                6'd3:    dout_d    = dout_q & ~wdata;
                6'd4:    oen_d     = wdata;
                6'd5:    inten_d   = wdata;
                6'd6:    inttype_d = wdata;
                6'd7:    intpol_d  = wdata;
                6'd8:    intboth_d = wdata;
                6'd9:    intstat_d = (intstat_q & ~wdata) | set;
                6'd10:   dben_d    = wdata;
                6'd11:   dbcnt_d   = PWDATA[DbWidth-1:0];
                default: ;
            endcase
        end
    end

    // read mux, zero-extended; unmapped offsets read 0
    always_comb begin
        rdata = '0;
        case (PADDR)
            6'd0:           rdata = 32'(filt_q);
            6'd1, 6'd2, 6'd3: rdata = 32'(dout_q);
            6'd4:           rdata = 32'(oen_q);
            6'd5:           rdata = 32'(inten_q);
            6'd6:           rdata = 32'(inttype_q);
            6'd7:           rdata = 32'(intpol_q);
            6'd8:           rdata = 32'(intboth_q);
            6'd9:           rdata = 32'(intstat_q);
            6'd10:          rdata = 32'(dben_q);
            6'd11:          rdata = 32'(dbcnt_q);
            default:        rdata = '0;
        endcase
    end

    // state registers; reset clears everything except the debounce threshold
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            cnt_q     <= '{default: '0};
            dout_q    <= '0;
            oen_q     <= '0;
            inten_q   <= '0;
            inttype_q <= '0;
            intpol_q  <= '0;
            intboth_q <= '0;
            intstat_q <= '0;
            dben_q    <= '0;
            dbcnt_q   <= DbDefault;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            filt_q    <= filt_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            oen_q     <= oen_d;
            inten_q   <= inten_d;
            inttype_q <= inttype_d;
            intpol_q  <= intpol_d;
            intboth_q <= intboth_d;
            intstat_q <= intstat_d;
            dben_q    <= dben_d;
            dbcnt_q   <= dbcnt_d;
        end
    end
endmodule

// File: tb/tb_apb_gpio_ext.sv
// tb_apb_gpio_ext: directed and random APB/pad stimulus checked against a per-pin behavioural model
module tb_apb_gpio_ext;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:2]  PADDR = '0;
    logic [31:0] PWDATA = '0, PRDATA;
    logic        PREADY, PSLVERR, COMBINT;
    logic [15:0] PORTIN = '0, PORTOUT, PORTEN, GPIOINT;
    int          checks = 0, failures = 0;

    logic [15:0] m_s1, m_s2, m_filt, m_dout, m_oen, m_inten, m_type, m_pol, m_both, m_stat, m_dben;
    int          m_dbcnt;
    int          m_cnt [16];
    logic [31:0] v;
    logic [31:0] pre [12];

    always #5 PCLK = ~PCLK;

    apb_gpio_ext dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .PORTIN(PORTIN), .PORTOUT(PORTOUT), .PORTEN(PORTEN), .GPIOINT(GPIOINT), .COMBINT(COMBINT)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0:       return {16'h0, m_filt};
            1, 2, 3: return {16'h0, m_dout};
            4:       return {16'h0, m_oen};
            5:       return {16'h0, m_inten};
            6:       return {16'h0, m_type};
            7:       return {16'h0, m_pol};
            8:       return {16'h0, m_both};
            9:       return {16'h0, m_stat};
            10:      return {16'h0, m_dben};
            11:      return 32'(m_dbcnt);
            default: return 32'h0;
        endcase
    endfunction

    // advance the model by one PCLK edge using the inputs currently driven
    task automatic m_step();
        logic [15:0] nf, set, w;
        int n;
        if (PRESET) begin
            {m_s1, m_s2, m_filt, m_dout, m_oen, m_inten, m_type, m_pol, m_both, m_stat, m_dben} = '0;
            m_dbcnt = 4;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        n  = (m_dbcnt == 0) ? 1 : m_dbcnt;
        nf = m_filt;
        for (int i = 0; i < 16; i++) begin
            if (!m_dben[i]) nf[i] = m_s2[i];
            else if (m_s2[i] == m_filt[i]) m_cnt[i] = 0;
            else if (m_cnt[i] + 1 >= n) begin
                nf[i] = m_s2[i];
                m_cnt[i] = 0;
            end else m_cnt[i] = m_cnt[i] + 1;
        end
        for (int i = 0; i < 16; i++) begin
            if (!m_type[i]) set[i] = (nf[i] == m_pol[i]);
            else if (m_both[i]) set[i] = (nf[i] != m_filt[i]);
            else if (m_pol[i]) set[i] = nf[i] && !m_filt[i];
            else set[i] = !nf[i] && m_filt[i];
        end
        w = PWDATA[15:0];
        if (PSEL && PENABLE && PWRITE) begin
            case (int'(PADDR))
                1:  m_dout = w;
                2:  m_dout = m_dout | w;
                3:  m_dout = m_dout & ~w;
                4:  m_oen = w;
                5:  m_inten = w;
                6:  m_type = w;
                7:  m_pol = w;
                8:  m_both = w;
                9:  m_stat = m_stat & ~w;
                10: m_dben = w;
                11: m_dbcnt = int'(PWDATA[7:0]);
                default: ;
            endcase
        end
        m_stat = m_stat | set;
        m_filt = nf;
        m_s2   = m_s1;
        m_s1   = PORTIN;
    endtask

    task automatic tick();
        m_step();
        @(posedge PCLK);
        #1;
        check("portout", PORTOUT, m_dout);
        check("porten", PORTEN, m_oen);
        check("gpioint", GPIOINT, m_stat & m_inten);
        check("combint", COMBINT, |(m_stat & m_inten));
        check("pready", PREADY, 1);
        if (!(PSEL && PENABLE)) begin
            check("idle_prdata", PRDATA, 0);
            check("idle_pslverr", PSLVERR, 0);
        end
    endtask

    task automatic apb_write(input int a, input logic [31:0] d);
        PSEL = 1; PADDR = 6'(a); PWRITE = 1; PWDATA = d; PENABLE = 0;
        tick();
        PENABLE = 1; #1;
        check("wr_pslverr", PSLVERR, 32'(a >= 12));
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input int a, input string tag, output logic [31:0] got);
        PSEL = 1; PADDR = 6'(a); PWRITE = 0; PENABLE = 0;
        tick();
        PENABLE = 1; #1;
        got = PRDATA;
        check(tag, got, m_read(a));
        check({tag, "_pslverr"}, PSLVERR, 32'(a >= 12));
        tick();
        PSEL = 0; PENABLE = 0;
    endtask

    initial begin
        // reset values, read while reset is still held
        tick();
        tick();
        check("rst_portout", PORTOUT, 0);
        check("rst_combint", COMBINT, 0);
        for (int a = 0; a < 12; a++) begin
            apb_read(a, "rst_read", v);
            check("rst_value", v, (a == 11) ? 32'd4 : 32'd0);
        end
        PRESET = 0;
        tick();

        // set/clear outputs
        apb_write(4, 32'h00FF);
        apb_write(1, 32'h0F0F);
        check("outen", PORTEN, 32'h00FF);
        check("dataout", PORTOUT, 32'h0F0F);
        apb_write(2, 32'h00F0);
        check("outset", PORTOUT, 32'h0FFF);
        apb_write(3, 32'h0F00);
        check("outclr", PORTOUT, 32'h00FF);

        // edge interrupt on pin 3
        apb_write(6, 32'hFFFF);
        apb_write(7, 32'h0008);
        apb_write(5, 32'h0008);
        apb_write(9, 32'hFFFF);
        check("edge_idle", COMBINT, 0);
        PORTIN[3] = 1;
        tick();
        tick();
        check("edge_early", COMBINT, 0);
        tick();
        check("edge_gpioint", GPIOINT, 32'h0008);
        check("edge_combint", COMBINT, 1);
        apb_read(9, "edge_stat_rd", v);
        check("edge_stat", v, 32'h0008);
        apb_write(9, 32'h0008);
        check("edge_w1c", COMBINT, 0);
        PORTIN[3] = 0;
        repeat (4) tick();
        check("fall_ignored", COMBINT, 0);
        PORTIN[3] = 1;
        repeat (4) tick();
        check("rise_again", COMBINT, 1);
        apb_write(8, 32'h0008);
        apb_write(9, 32'h0008);
        check("both_clr", COMBINT, 0);
        PORTIN[3] = 0;
        repeat (3) tick();
        check("both_fall", GPIOINT, 32'h0008);

        // level interrupt on pin 5 (active low)
        apb_write(6, 32'hFFDF);
        apb_write(9, 32'hFFFF);
        apb_read(9, "lvl_rd", v);
        check("lvl_persist", v, 32'h0020);
        PORTIN[5] = 1;
        repeat (3) tick();
        apb_write(9, 32'h0020);
        apb_read(9, "lvl_rd2", v);
        check("lvl_cleared", v, 0);

        // debounce on pin 0, N = 5
        apb_write(10, 32'h0001);
        apb_write(11, 32'd5);
        apb_write(8, 32'h0009);
        apb_write(5, 32'h0009);
        apb_write(9, 32'hFFFF);
        PORTIN[0] = 1;
        repeat (3) tick();
        PORTIN[0] = 0;
        repeat (8) tick();
        apb_read(0, "db_data_rd", v);
        check("db_glitch_data", v & 32'h1, 0);
        apb_read(9, "db_stat_rd", v);
        check("db_glitch_int", v, 0);
        PORTIN[0] = 1;
        repeat (6) tick();
        check("db_before", GPIOINT, 0);
        tick();
        check("db_at_6", GPIOINT, 32'h0001);
        repeat (3) tick();
        PORTIN[0] = 0;
        apb_read(0, "db_data_rd2", v);
        check("db_data_high", v & 32'h1, 1);
        repeat (20) tick();

        // error response and unmapped writes
        apb_read(12, "err_rd", v);
        check("err_prdata", v, 0);
        for (int a = 0; a < 12; a++) apb_read(a, "pre_rd", pre[a]);
        apb_write(16, 32'hFFFF);
        for (int a = 0; a < 12; a++) begin
            apb_read(a, "post_rd", v);
            check("unmapped_keep", v, pre[a]);
        end

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int a;
            if ($urandom_range(0, 3) == 0) PORTIN = PORTIN ^ (16'(1) << $urandom_range(0, 15));
            a = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0:       apb_write(a, (a == 11) ? 32'($urandom_range(0, 7)) : $urandom);
                1:       apb_read(a, "rnd_rd", v);
                default: tick();
            endcase
        end

        // reset during a write access phase aborts it
        PSEL = 1; PADDR = 6'd1; PWRITE = 1; PWDATA = 32'hFFFF; PENABLE = 0;
        tick();
        PENABLE = 1; PRESET = 1;
        tick();
        PSEL = 0; PENABLE = 0; PWRITE = 0; PRESET = 0;
        check("rst_abort_portout", PORTOUT, 0);
        check("rst_abort_combint", COMBINT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
